// File: rtl/pattern_pkg.sv
// Shared definitions for both ends of the serial 1011 pattern link.
// Holds the FSM state encoding and the default pattern both ends agree on.
package pattern_pkg;

    localparam int         PAT_W_DEF = 4;
    localparam logic [3:0] DEF_PAT_C = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_GAP  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/pattern_shift_reg.sv
// Load/shift-left register; its MSB is the transmitted bit.
// Zeros shift in from the LSB side, so an exhausted pattern reads as idle.
module pattern_shift_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic [W-1:0] q
);

    // Load takes priority over shift; otherwise the contents hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= {W{1'b0}};
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[W-2:0], 1'b0};
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/pattern_tx_1011.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first a requested
// number of times, with an optional idle gap between repetitions.
module pattern_tx_1011
    import pattern_pkg::*;
#(
    parameter int               PAT_W   = PAT_W_DEF,
    parameter int               CNT_W   = 8,
    parameter int               GAP     = 0,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PAT_C)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             use_default,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic [CNT_W-1:0] repeat_in,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done
);

    localparam int BC_W  = $clog2(PAT_W);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    state_t             state_r;
    logic [BC_W-1:0]    bit_cnt_r;
    logic [CNT_W-1:0]   rep_cnt_r;
    logic [CNT_W-1:0]   rep_tgt_r;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic [PAT_W-1:0]   pat_r;

    logic               accept_s;
    logic               last_bit_s;
    logic               last_rep_s;
    logic               gap_end_s;
    logic [PAT_W-1:0]   pat_sel_s;
    logic               sr_load_s;
    logic               sr_shift_s;
    logic [PAT_W-1:0]   sr_din_s;
    logic [PAT_W-1:0]   sr_q_s;

    // Decode acceptance and end-of-bit / end-of-repetition / end-of-gap conditions.
    always_comb begin
        accept_s   = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        last_bit_s = (bit_cnt_r == BC_W'(PAT_W - 1));
        last_rep_s = (rep_cnt_r == (rep_tgt_r - CNT_W'(1)));
        gap_end_s  = (gap_cnt_r == GAP_W'(GAP - 1));
        if (use_default) begin
            pat_sel_s = DEF_PAT;
        end else begin
            pat_sel_s = pattern_in;
        end
    end

    // Shift-register control: loading zeros doubles as the clear, keeping serial_out low when idle.
    always_comb begin
        sr_load_s  = 1'b0;
        sr_shift_s = 1'b0;
        sr_din_s   = {PAT_W{1'b0}};
        case (state_r)
            ST_IDLE, ST_DONE: begin
                sr_load_s = 1'b1;
                if (accept_s && (repeat_in != {CNT_W{1'b0}})) begin
                    sr_din_s = pat_sel_s;
                end else begin
                    sr_din_s = {PAT_W{1'b0}};
                end
            end
            ST_SEND: begin
                if (last_bit_s) begin
                    sr_load_s = 1'b1;
                    if (!last_rep_s && (GAP == 0)) begin
                        sr_din_s = pat_r;
                    end else begin
                        sr_din_s = {PAT_W{1'b0}};
                    end
                end else begin
                    sr_shift_s = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_end_s) begin
                    sr_load_s = 1'b1;
                    sr_din_s  = pat_r;
                end else begin
                    sr_load_s = 1'b0;
                end
            end
            default: begin
                sr_load_s = 1'b1;
                sr_din_s  = {PAT_W{1'b0}};
            end
        endcase
    end

    pattern_shift_reg #(
        .W (PAT_W)
    ) u_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (sr_load_s),
        .shift (sr_shift_s),
        .din   (sr_din_s),
        .q     (sr_q_s)
    );

    assign serial_out = sr_q_s[PAT_W-1];

    // Transmit FSM with counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= {BC_W{1'b0}};
            rep_cnt_r   <= {CNT_W{1'b0}};
            rep_tgt_r   <= {CNT_W{1'b0}};
            gap_cnt_r   <= {GAP_W{1'b0}};
            pat_r       <= {PAT_W{1'b0}};
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            done        <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        pat_r     <= pat_sel_s;
                        rep_tgt_r <= repeat_in;
                        rep_cnt_r <= {CNT_W{1'b0}};
                        bit_cnt_r <= {BC_W{1'b0}};
                        if (repeat_in != {CNT_W{1'b0}}) begin
                            state_r     <= ST_SEND;
                            bit_valid   <= 1'b1;
                            frame_start <= 1'b1;
                            busy        <= 1'b1;
                        end else begin
                            state_r   <= ST_DONE;
                            done      <= 1'b1;
                            bit_valid <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end else begin
                        state_r   <= ST_IDLE;
                        bit_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (last_bit_s) begin
                        bit_cnt_r <= {BC_W{1'b0}};
                        rep_cnt_r <= rep_cnt_r + CNT_W'(1);
                        if (last_rep_s) begin
                            state_r   <= ST_DONE;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            bit_valid <= 1'b0;
                        end else if (GAP > 0) begin
                            state_r   <= ST_GAP;
                            gap_cnt_r <= {GAP_W{1'b0}};
                            bit_valid <= 1'b0;
                        end else begin
                            frame_start <= 1'b1;
                            bit_valid   <= 1'b1;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r + BC_W'(1);
                    end
                end
                ST_GAP: begin
                    if (gap_end_s) begin
                        state_r     <= ST_SEND;
                        bit_valid   <= 1'b1;
                        frame_start <= 1'b1;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bit_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_tx_1011.sv
// Scoreboard bench for pattern_tx_1011: back-to-back (GAP=0) and gapped (GAP=2)
// instances share stimulus; a cycle-level reference stream is checked every cycle.
module tb_pattern_tx_1011;

    typedef struct packed {
        logic so;
        logic bv;
        logic fs;
        logic bz;
        logic dn;
    } exp_t;

    localparam exp_t IDLE_E = 5'b00000;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       use_default;
    logic [3:0] pattern_in;
    logic [7:0] repeat_in;

    logic so0, bv0, fs0, bz0, dn0;
    logic so1, bv1, fs1, bz1, dn1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t cur0 = IDLE_E;
    exp_t cur1 = IDLE_E;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    always #5 clk = ~clk;

    pattern_tx_1011 #(.GAP(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .use_default(use_default),
        .pattern_in(pattern_in), .repeat_in(repeat_in),
        .serial_out(so0), .bit_valid(bv0), .frame_start(fs0), .busy(bz0), .done(dn0)
    );

    pattern_tx_1011 #(.GAP(2)) dut1 (
        .clk(clk), .rst(rst), .start(start), .use_default(use_default),
        .pattern_in(pattern_in), .repeat_in(repeat_in),
        .serial_out(so1), .bit_valid(bv1), .frame_start(fs1), .busy(bz1), .done(dn1)
    );

    // Reference: every accepted start expands into the full per-cycle output stream.
    task automatic push_frame(input int which, input logic [3:0] pat, input int reps, input int gap);
        exp_t e;
        for (int r = 0; r < reps; r++) begin
            for (int k = 0; k < 4; k++) begin
                e = '{so: pat[3-k], bv: 1'b1, fs: (k == 0), bz: 1'b1, dn: 1'b0};
                if (which == 0) q0.push_back(e); else q1.push_back(e);
            end
            if (r < reps - 1) begin
                for (int g = 0; g < gap; g++) begin
                    e = '{so: 1'b0, bv: 1'b0, fs: 1'b0, bz: 1'b1, dn: 1'b0};
                    if (which == 0) q0.push_back(e); else q1.push_back(e);
                end
            end
        end
        e = '{so: 1'b0, bv: 1'b0, fs: 1'b0, bz: 1'b0, dn: 1'b1};
        if (which == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // Monitor: pops this cycle's expectation for each DUT and compares.
    initial begin
        exp_t got;
        forever begin
            @(negedge clk);
            cycle++;
            cur0 = (q0.size() > 0) ? q0.pop_front() : IDLE_E;
            cur1 = (q1.size() > 0) ? q1.pop_front() : IDLE_E;
            got = {so0, bv0, fs0, bz0, dn0};
            checks++;
            if (got !== cur0) begin
                failures++;
                $display("FAIL gap0_outputs cycle=%0d so/bv/fs/busy/done got=%b required=%b", cycle, got, cur0);
            end
            got = {so1, bv1, fs1, bz1, dn1};
            checks++;
            if (got !== cur1) begin
                failures++;
                $display("FAIL gap2_outputs cycle=%0d so/bv/fs/busy/done got=%b required=%b", cycle, got, cur1);
            end
        end
    end

    // Drive one cycle of inputs; the model accepts start only where busy is expected low.
    task automatic drive(input logic r, input logic s, input logic ud, input logic [3:0] p, input logic [7:0] rp);
        logic [3:0] pat;
        rst = r; start = s; use_default = ud; pattern_in = p; repeat_in = rp;
        pat = ud ? 4'b1011 : p;
        if (r) begin
            q0.delete();
            q1.delete();
        end else if (s) begin
            if (!cur0.bz) push_frame(0, pat, int'(rp), 0);
            if (!cur1.bz) push_frame(1, pat, int'(rp), 2);
        end else begin
            pat = 4'b0000;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 4'($urandom), 8'($urandom));
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((cur0.bz || cur0.dn || q0.size() != 0 || cur1.bz || cur1.dn || q1.size() != 0) && n < limit) begin
            idle();
            n++;
        end
        checks++;
        if (n >= limit) begin
            failures++;
            $display("FAIL idle_timeout waited=%0d cycles required=<%0d", n, limit);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; use_default = 1'b0; pattern_in = 4'h0; repeat_in = 8'h00;
        @(negedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 4'h0, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 4'h0, 8'd0);
        idle(); idle();

        // Single default frame, then back-to-back repeats of an explicit pattern.
        drive(1'b0, 1'b1, 1'b1, 4'b0000, 8'd1);
        wait_idle(40);
        idle();
        drive(1'b0, 1'b1, 1'b0, 4'b1011, 8'd3);
        wait_idle(60);
        idle();

        // Zero count, and a start while busy that must be ignored.
        drive(1'b0, 1'b1, 1'b0, 4'b1111, 8'd0);
        wait_idle(10);
        idle();
        drive(1'b0, 1'b1, 1'b0, 4'b1101, 8'd2);
        idle();
        drive(1'b0, 1'b1, 1'b0, 4'b0000, 8'd5);
        wait_idle(60);
        idle();

        // Reset mid-transmission, then a clean restart.
        drive(1'b0, 1'b1, 1'b0, 4'b1011, 8'd1);
        idle();
        drive(1'b1, 1'b0, 1'b0, 4'h0, 8'd0);
        idle(); idle();
        drive(1'b0, 1'b1, 1'b0, 4'b1001, 8'd1);
        wait_idle(40);
        idle();

        // Start coincident with done: no IDLE bubble.
        drive(1'b0, 1'b1, 1'b0, 4'b1110, 8'd1);
        n = 0;
        while (!cur0.dn && n < 20) begin
            idle();
            n++;
        end
        drive(1'b0, 1'b1, 1'b0, 4'b0110, 8'd2);
        wait_idle(60);
        idle();

        // Maximum repeat count must not wrap.
        drive(1'b0, 1'b1, 1'b1, 4'b0000, 8'd255);
        wait_idle(2000);
        idle();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) == 0),
                  1'($urandom),
                  4'($urandom),
                  ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 4)));
        end
        wait_idle(200);
        idle(); idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pattern_tx_1011.md
Name: pattern_tx_1011

Overview:
Serial pattern transmitter: the transmit-side counterpart of the team's serial 1011 sequence detector. Accepts a parallel pattern word and a repeat count on a start strobe, then shifts the pattern out MSB-first, one bit per clock, the requested number of times. An optional idle gap of zero bits separates repetitions. Used as the stimulus/source end of the serial pattern link, driving the detector's sequence_in.

Parameters:
PAT_W, 4, pattern width in bits (minimum 2)
CNT_W, 8, repeat-count width
GAP, 0, number of idle (0, invalid) bit slots inserted between repetitions; 0 means back-to-back
DEF_PAT, 4'b1011, pattern value used when use_default is high

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request to begin a transmission; sampled only when busy is low
use_default  input  1  sampled with start; 1 selects DEF_PAT instead of pattern_in
pattern_in  input  PAT_W  pattern to transmit, MSB sent first
repeat_in  input  CNT_W  number of pattern repetitions (0 is legal)
serial_out  output  1  transmitted bit; forced to 0 when bit_valid is low
bit_valid  output  1  serial_out carries a pattern bit this cycle
frame_start  output  1  high with the first (MSB) bit of each repetition
busy  output  1  transmission in progress (SEND or GAP state)
done  output  1  one-cycle pulse after the last bit of the last repetition

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- All outputs are registered (Moore style). Reset value is 0 for every output. Internal state resets to IDLE, and the counters and shift register reset to 0.
- Reset has priority over every other input. If rst is asserted mid-transmission, all outputs are 0 after that edge and the in-flight pattern is discarded; no done pulse is produced.
- States: IDLE, SEND, GAP, DONE.
- IDLE: outputs low. When start=1, latch the pattern (DEF_PAT if use_default=1, else pattern_in) and latch repeat_in.
  - repeat_in != 0: go to SEND.
  - repeat_in == 0: go to DONE; no bits are sent.
- Latency: the first bit appears on serial_out, with bit_valid=1 and frame_start=1, in the cycle after the edge on which start was sampled.
- SEND:
  - Presents bit[PAT_W-1-k] on bit k of each repetition.
  - A bit counter runs 0..PAT_W-1 and wraps to 0 at the end of each repetition. The repetition counter increments at each wrap.
  - After the last bit of a repetition:
    - if repetitions remain and GAP>0: go to GAP;
    - if repetitions remain and GAP=0: stay in SEND, reloading the latched pattern, with frame_start=1 on the next bit;
    - if no repetitions remain: go to DONE.
- GAP: lasts exactly GAP cycles with bit_valid=0 and serial_out=0, then returns to SEND.
- DONE: one cycle with done=1, busy=0 and bit_valid=0, then go to IDLE.
  - start is accepted in the DONE cycle as well as in IDLE, because busy=0 in both. If accepted, the next state is SEND (or DONE again if repeat_in=0).
- start while busy=1 is ignored and not queued. pattern_in, use_default and repeat_in are don't-care except on the accepting edge.
- Total cycles from accepted start to done, for repeat count R>0: R*PAT_W + (R-1)*GAP, then done on the following cycle.
- The repetition counter is CNT_W bits wide. R = 2^CNT_W-1 must complete without wrap-around.

Decomposition:
- Shared package pattern_pkg holds:
  - the state encoding constants for IDLE/SEND/GAP/DONE (2-bit);
  - the DEF_PAT value 4'b1011, shared with the detector so that both ends agree on the pattern;
  - PAT_W default.
- One sub-module is natural: pattern_shift_reg, a PAT_W-bit load/shift-left register whose MSB is serial_out. The FSM and counters stay in the top module.

Test Plan:
- Single frame: use_default=1, repeat_in=1, GAP=0, start in cycle 0 → serial_out 1,0,1,1 with bit_valid=1 in cycles 1–4, frame_start=1 in cycle 1 only, busy=1 in cycles 1–4, done=1 in cycle 5. A detector driven from serial_out asserts detector_output once, one cycle after the last 1.
- Back-to-back: pattern_in=4'b1011, repeat_in=3, GAP=0 → 12 contiguous bits 1011_1011_1011, frame_start in cycles 1, 5 and 9, done in cycle 13. The detector fires exactly 3 times.
- Gap insertion: GAP=2, repeat_in=2 → bits 1,0,1,1, then 2 cycles with bit_valid=0/serial_out=0, then 1,0,1,1; done in cycle 11.
- Zero count and busy start: repeat_in=0 → done=1 in cycle 1 with no bit_valid. Separately, a second start with pattern_in=4'b0000 pulsed in cycle 2 of an active run is ignored and the original bits are unchanged.
- Reset mid-operation: rst=1 on the edge ending cycle 2 of a 1011 run → all outputs 0 from cycle 3, no done pulse. A new start after reset transmits cleanly from the MSB.
- Start in DONE cycle: start asserted coincident with done → the next frame's first bit follows on the next cycle, with no IDLE bubble.
